fetch_ctrl: RTL and testbench

- Program-counter and instruction-fetch sequencer that sits directly upstream of the ALU/execute stage.
- Fetches each instruction from instruction memory and issues it downstream, then waits for execute to retire it.
- Selects the next PC from the retired instruction's branch fields and the ALU's `alu_zero` flag, using a small writable branch-target LUT.

---
 rtl/fetch_ctrl_pkg.sv | 21 ++
 rtl/fetch_ctrl_branch_lut.sv | 31 +++
 rtl/fetch_ctrl.sv | 132 +++++++++++++
 tb/tb_fetch_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and default widths for the fetch sequencer.
package fetch_ctrl_pkg;

    localparam int unsigned FC_PC_W    = 10;
    localparam int unsigned FC_INSTR_W = 9;
    localparam int unsigned FC_CNT_W   = 16;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        EXEC,
        HALT
    } fc_state_e;

    // Saturating increment for the retired-instruction counter.
    function automatic logic [FC_CNT_W-1:0] sat_inc(input logic [FC_CNT_W-1:0] v);
        return (v == {FC_CNT_W{1'b1}}) ? v : v + FC_CNT_W'(1);
    endfunction

endpackage

// File: rtl/fetch_ctrl_branch_lut.sv
// Branch-target LUT: register array, async clear, one sync write port, one comb read port.
module branch_lut #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = 10,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [W-1:0]     wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [W-1:0]     rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Same-cycle read of a written entry sees the old value.
    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_ctrl.sv
// PC / instruction-fetch sequencer feeding the execute stage.
// Optional retired-instruction counter port instr_cnt enabled by macro INSTR_CNT_EN.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned PC_W       = FC_PC_W,
    parameter int unsigned INSTR_W    = FC_INSTR_W,
    parameter int unsigned LUT_DEPTH  = 16,
    parameter int unsigned START_ADDR = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic                         imem_req,
    output logic [PC_W-1:0]              imem_addr,
    input  logic                         imem_rdy,
    input  logic [INSTR_W-1:0]           imem_data,
    output logic [INSTR_W-1:0]           instr,
    output logic                         instr_vld,
    input  logic                         ex_done,
    input  logic                         alu_zero,
    input  logic                         br_en,
    input  logic                         br_abs,
    input  logic [$clog2(LUT_DEPTH)-1:0] br_idx,
    input  logic                         halt_req,
    input  logic                         lut_we,
    input  logic [$clog2(LUT_DEPTH)-1:0] lut_waddr,
    input  logic [PC_W-1:0]              lut_wdata,
`ifdef INSTR_CNT_EN
    output logic [FC_CNT_W-1:0]          instr_cnt,
`endif
    output logic                         done
);

    localparam int unsigned IDX_W = $clog2(LUT_DEPTH);

    fc_state_e       state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] lut_rdata;
    logic [PC_W-1:0] pc_next_c;

    branch_lut #(
        .DEPTH (LUT_DEPTH),
        .W     (PC_W),
        .IDX_W (IDX_W)
    ) u_lut (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (lut_we),
        .waddr (lut_waddr),
        .wdata (lut_wdata),
        .raddr (br_idx),
        .rdata (lut_rdata)
    );

    // Next PC for a non-halt retire; relative offsets wrap modulo 2^PC_W.
    always_comb begin
        pc_next_c = pc + PC_W'(1);
        if (br_en && alu_zero) begin
            pc_next_c = br_abs ? lut_rdata : pc + lut_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= PC_W'(START_ADDR);
            imem_req  <= 1'b0;
            instr     <= '0;
            instr_vld <= 1'b0;
            done      <= 1'b0;
        end else begin
            instr_vld <= 1'b0;
            case (state)
                IDLE, HALT: begin
                    if (start) begin
                        state    <= FETCH;
                        pc       <= PC_W'(START_ADDR);
                        imem_req <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                FETCH: begin
                    if (imem_rdy) begin
                        state     <= ISSUE;
                        instr     <= imem_data;
                        imem_req  <= 1'b0;
                        instr_vld <= 1'b1;
                    end
                end
                ISSUE: begin
                    state <= EXEC;
                end
                EXEC: begin
                    if (ex_done) begin
                        if (halt_req) begin
                            state <= HALT;
                            done  <= 1'b1;
                        end else begin
                            state    <= FETCH;
                            pc       <= pc_next_c;
                            imem_req <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign imem_addr = pc;

`ifdef INSTR_CNT_EN
    logic start_acc_c;

    assign start_acc_c = start && ((state == IDLE) || (state == HALT));

    // Counts every retire in EXEC, halt included; an accepted start clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_cnt <= '0;
        end else if (start_acc_c) begin
            instr_cnt <= '0;
        end else if ((state == EXEC) && ex_done) begin
            instr_cnt <= sat_inc(instr_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_fetch_ctrl;

    localparam int unsigned PC_W       = 10;
    localparam int unsigned INSTR_W    = 9;
    localparam int unsigned LUT_DEPTH  = 16;
    localparam int unsigned IDX_W      = 4;
    localparam int          START_ADDR = 0;
    localparam int          PC_MOD     = 1024;

    logic               clk       = 1'b0;
    logic               rst_n     = 1'b0;
    logic               start     = 1'b0;
    logic               imem_rdy  = 1'b0;
    logic [INSTR_W-1:0] imem_data = '0;
    logic               ex_done   = 1'b0;
    logic               alu_zero  = 1'b0;
    logic               br_en     = 1'b0;
    logic               br_abs    = 1'b0;
    logic [IDX_W-1:0]   br_idx    = '0;
    logic               halt_req  = 1'b0;
    logic               lut_we    = 1'b0;
    logic [IDX_W-1:0]   lut_waddr = '0;
    logic [PC_W-1:0]    lut_wdata = '0;

    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] instr;
    logic               instr_vld;
    logic               done;
`ifdef INSTR_CNT_EN
    logic [15:0]        instr_cnt;
`endif

    int total = 0;
    int bad   = 0;

    // Behavioural model: phase flags plus integer PC / LUT arithmetic.
    int m_lut [LUT_DEPTH];
    int m_pc, m_instr, m_cnt;
    bit m_idle, m_req, m_vld, m_exec, m_done;

    // Inputs as seen by the DUT at the upcoming edge.
    bit s_rst, s_start, s_rdy, s_exd, s_z, s_br, s_abs, s_halt, s_we;
    int s_data, s_idx, s_wa, s_wd;

    int issued [$];

    always #5 clk = ~clk;

    fetch_ctrl #(
        .PC_W       (PC_W),
        .INSTR_W    (INSTR_W),
        .LUT_DEPTH  (LUT_DEPTH),
        .START_ADDR (START_ADDR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_rdy  (imem_rdy),
        .imem_data (imem_data),
        .instr     (instr),
        .instr_vld (instr_vld),
        .ex_done   (ex_done),
        .alu_zero  (alu_zero),
        .br_en     (br_en),
        .br_abs    (br_abs),
        .br_idx    (br_idx),
        .halt_req  (halt_req),
        .lut_we    (lut_we),
        .lut_waddr (lut_waddr),
        .lut_wdata (lut_wdata),
`ifdef INSTR_CNT_EN
        .instr_cnt (instr_cnt),
`endif
        .done      (done)
    );

    function automatic void chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < int'(LUT_DEPTH); i++) m_lut[i] = 0;
        m_pc    = START_ADDR;
        m_instr = 0;
        m_cnt   = 0;
        m_idle  = 1'b1;
        m_req   = 1'b0;
        m_vld   = 1'b0;
        m_exec  = 1'b0;
        m_done  = 1'b0;
    endfunction

    function automatic int target_pc(input int pc);
        int off;
        if (s_br && s_z) begin
            if (s_abs) return m_lut[s_idx];
            off = (m_lut[s_idx] >= PC_MOD / 2) ? m_lut[s_idx] - PC_MOD : m_lut[s_idx];
            return ((pc + off) % PC_MOD + PC_MOD) % PC_MOD;
        end
        return (pc + 1) % PC_MOD;
    endfunction

    function automatic void model_step();
        bit was_vld;
        if (!s_rst) begin
            model_reset();
            return;
        end
        was_vld = m_vld;
        m_vld   = 1'b0;
        if (m_idle || m_done) begin
            if (s_start) begin
                m_idle = 1'b0;
                m_done = 1'b0;
                m_pc   = START_ADDR;
                m_req  = 1'b1;
                m_cnt  = 0;
            end
        end else if (m_req) begin
            if (s_rdy) begin
                m_req   = 1'b0;
                m_instr = s_data;
                m_vld   = 1'b1;
            end
        end else if (was_vld) begin
            m_exec = 1'b1;
        end else if (m_exec && s_exd) begin
            m_exec = 1'b0;
            if (m_cnt < 65535) m_cnt++;
            if (s_halt) m_done = 1'b1;
            else begin
                m_pc  = target_pc(m_pc);
                m_req = 1'b1;
            end
        end
        // LUT write lands after this cycle's read.
        if (s_we) m_lut[s_wa] = s_wd;
    endfunction

    function automatic void compare_all();
        chk("imem_req", int'(imem_req), int'(m_req));
        chk("imem_addr", int'(imem_addr), m_pc);
        chk("instr_vld", int'(instr_vld), int'(m_vld));
        chk("instr", int'(instr), m_instr);
        chk("done", int'(done), int'(m_done));
`ifdef INSTR_CNT_EN
        chk("instr_cnt", int'(instr_cnt), m_cnt);
`endif
    endfunction

    // One clock: snapshot inputs, advance model, sample DUT 1ns after the edge, clear pulses.
    task automatic cyc();
        s_rst   = rst_n;
        s_start = start;
        s_rdy   = imem_rdy;
        s_data  = int'(imem_data);
        s_exd   = ex_done;
        s_z     = alu_zero;
        s_br    = br_en;
        s_abs   = br_abs;
        s_halt  = halt_req;
        s_idx   = int'(br_idx);
        s_we    = lut_we;
        s_wa    = int'(lut_waddr);
        s_wd    = int'(lut_wdata);
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        if (instr_vld) issued.push_back(int'(imem_addr));
        start    = 1'b0;
        imem_rdy = 1'b0;
        ex_done  = 1'b0;
        halt_req = 1'b0;
        br_en    = 1'b0;
        br_abs   = 1'b0;
        alu_zero = 1'b0;
        lut_we   = 1'b0;
    endtask

    task automatic lut_wr(input int idx, input int data);
        lut_we    = 1'b1;
        lut_waddr = IDX_W'(idx);
        lut_wdata = PC_W'(data);
        cyc();
    endtask

    // Fetch with rdy after rdy_lat cycles, retire ex_lat cycles after issue.
    task automatic run_instr(input int rdy_lat, input int ex_lat, input bit hlt,
                             input bit br, input bit abs_t, input bit z, input int idx);
        for (int i = 1; i < rdy_lat; i++) cyc();
        imem_rdy  = 1'b1;
        imem_data = INSTR_W'($urandom);
        cyc();
        for (int i = 0; i < ex_lat; i++) cyc();
        ex_done  = 1'b1;
        halt_req = hlt;
        br_en    = br;
        br_abs   = abs_t;
        alu_zero = z;
        br_idx   = IDX_W'(idx);
        cyc();
    endtask

    initial begin
        int exp_seq [4];
        exp_seq = '{0, 1, 2, 3};
        model_reset();

        // Reset state
        repeat (2) cyc();
        chk("rst_imem_req", int'(imem_req), 0);
        chk("rst_instr_vld", int'(instr_vld), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_instr", int'(instr), 0);
        rst_n = 1'b1;
        repeat (2) cyc();
        chk("idle_no_req", int'(imem_req), 0);

        // start -> imem_req on the next cycle, addresses 0..3
        start = 1'b1;
        cyc();
        chk("start_req", int'(imem_req), 1);
        chk("start_addr", int'(imem_addr), 0);
        issued.delete();
        for (int i = 0; i < 4; i++) run_instr(1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        chk("seq_len", issued.size(), 4);
        for (int i = 0; i < 4 && i < issued.size(); i++) chk("seq_addr", issued[i], exp_seq[i]);

        // Absolute taken branch and its not-taken twin
        run_instr(1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        chk("pc_five", int'(imem_addr), 5);
        lut_wr(3, 40);
        run_instr(1, 2, 1'b0, 1'b1, 1'b1, 1'b1, 3);
        chk("abs_taken", int'(imem_addr), 40);
        lut_wr(0, 5);
        run_instr(1, 2, 1'b0, 1'b1, 1'b1, 1'b1, 0);
        chk("back_to_five", int'(imem_addr), 5);
        run_instr(1, 2, 1'b0, 1'b1, 1'b1, 1'b0, 3);
        chk("abs_not_taken", int'(imem_addr), 6);

        // Relative wrap below zero, then fall-through wrap to zero
        lut_wr(1, 1);
        run_instr(2, 1, 1'b0, 1'b1, 1'b1, 1'b1, 1);
        chk("pc_one", int'(imem_addr), 1);
        lut_wr(2, 10'h3FE);
        run_instr(1, 3, 1'b0, 1'b1, 1'b0, 1'b1, 2);
        chk("rel_wrap", int'(imem_addr), 1023);
        run_instr(1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        chk("inc_wrap", int'(imem_addr), 0);

        // Halt wins over a taken branch
        run_instr(1, 2, 1'b1, 1'b1, 1'b1, 1'b1, 3);
        chk("halt_done", int'(done), 1);
        repeat (4) cyc();
        chk("halt_no_req", int'(imem_req), 0);
        start = 1'b1;
        cyc();
        chk("restart_done", int'(done), 0);
        chk("restart_addr", int'(imem_addr), START_ADDR);
        chk("restart_req", int'(imem_req), 1);

        // Four instructions then halt; counter check
        for (int i = 0; i < 4; i++) run_instr(i + 1, 2 - (i % 2), 1'b0, 1'b0, 1'b0, 1'b0, 0);
        run_instr(1, 1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        chk("halt2_done", int'(done), 1);
`ifdef INSTR_CNT_EN
        chk("cnt_five", int'(instr_cnt), 5);
`endif
        start = 1'b1;
        cyc();
`ifdef INSTR_CNT_EN
        chk("cnt_cleared", int'(instr_cnt), 0);
`endif

        // Delayed rdy: request and address hold steady
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("hold_req", int'(imem_req), 1);
            chk("hold_addr", int'(imem_addr), 0);
        end
        imem_rdy  = 1'b1;
        imem_data = 9'h1A5;
        cyc();
        chk("late_vld", int'(instr_vld), 1);
        chk("late_instr", int'(instr), 9'h1A5);
        repeat (2) cyc();
        ex_done = 1'b1;
        cyc();

        // Async reset in the third fetch cycle
        cyc();
        cyc();
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_req_drop", int'(imem_req), 0);
        model_reset();
        repeat (2) cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            imem_rdy = 1'b1;
            ex_done  = 1'b1;
            cyc();
            chk("post_rst_no_vld", int'(instr_vld), 0);
        end

        // Randomized traffic
        for (int n = 0; n < 6000; n++) begin
            start     = (m_idle || m_done) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 29) == 0);
            imem_data = INSTR_W'($urandom);
            imem_rdy  = m_req && ($urandom_range(0, 2) == 0);
            ex_done   = m_exec ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            halt_req  = ($urandom_range(0, 11) == 0);
            br_en     = 1'($urandom_range(0, 1));
            br_abs    = 1'($urandom_range(0, 1));
            alu_zero  = 1'($urandom_range(0, 1));
            br_idx    = IDX_W'($urandom);
            lut_we    = ($urandom_range(0, 3) == 0);
            lut_waddr = IDX_W'($urandom);
            lut_wdata = PC_W'($urandom);
            if ($urandom_range(0, 999) == 0) begin
                #2;
                rst_n = 1'b0;
                #1;
                chk("rand_async_rst", int'(imem_req), 0);
                model_reset();
            end
            cyc();
            rst_n = 1'b1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
